// File: rtl/cla_seq_add.sv
// Multi-precision add/subtract sequencer: one BITS-wide carry-lookahead adder,
// stepped LSB chunk first, with the inter-chunk carry kept in a register.

module cla #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);
    logic [BITS-1:0] g;
    logic [BITS-1:0] p;
    logic [BITS:0]   c;
    logic            acc;
    logic            prop;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of generate/propagate products back to cin.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prop = 1'b0;
        c[0] = cin;
        for (int i = 0; i < BITS; i++) begin
            acc  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = acc | (prop & cin);
        end
    end

    assign sum  = p ^ c[BITS-1:0];
    assign cout = c[BITS];
endmodule

module cla_seq_add #(
    parameter int BITS  = 8,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORDS*BITS-1:0] a,
    input  logic [WORDS*BITS-1:0] b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORDS*BITS-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int W  = WORDS * BITS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;   // already inverted for subtract
    logic [BITS-1:0] chunk_a;
    logic [BITS-1:0] chunk_b;
    logic [BITS-1:0] chunk_sum;
    logic            chunk_cout;

    assign chunk_a = a_q[int'(cnt)*BITS +: BITS];
    assign chunk_b = b_q[int'(cnt)*BITS +: BITS];

    cla #(.BITS(BITS)) u_cla (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        a_q       <= a;
                        b_q       <= sub ? ~b : b;
                        carry     <= sub ? 1'b1 : cin;
                        cnt       <= '0;
                        sum       <= '0;
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(cnt)*BITS +: BITS] <= chunk_sum;
                    carry <= chunk_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        cout      <= chunk_cout;
                        ovf       <= (a_q[W-1] == b_q[W-1]) & (chunk_sum[BITS-1] != a_q[W-1]);
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_add.sv
// Directed bench for cla_seq_add (BITS=8, WORDS=4) with hand-computed results.

module tb_cla_seq_add;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    cla_seq_add #(.BITS(8), .WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".sum"},       64'(sum),       64'd0);
        chk({tag, ".cout"},      64'(cout),      64'd0);
        chk({tag, ".ovf"},       64'(ovf),       64'd0);
    endtask

    // Drive a request at a negedge; returns after the accept edge (next negedge).
    task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                         input logic vsub, input logic vcin, input string tag);
        @(negedge clk);
        chk({tag, ".ready_before"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        a = va; b = vb; sub = vsub; cin = vcin;
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble operands after accept; the result must not depend on them.
        a = ~va; b = 32'h5A5A_A5A5; sub = ~vsub; cin = ~vcin;
        chk({tag, ".busy_after_accept"}, 64'(busy), 64'd1);
    endtask

    // Count cycles from accept to rsp_valid, bounded.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd4);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] es,
                              input logic ec, input logic eo);
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".sum"},   64'(sum),       64'(es));
        chk({tag, ".cout"},  64'(cout),      64'(ec));
        chk({tag, ".ovf"},   64'(ovf),       64'(eo));
        chk({tag, ".ready_in_done"}, 64'(req_ready), 64'd0);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".valid_dropped"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".ready_back"},    64'(req_ready), 64'd1);
    endtask

    task automatic full_op(input logic [31:0] va, input logic [31:0] vb,
                           input logic vsub, input logic vcin,
                           input logic [31:0] es, input logic ec, input logic eo,
                           input string tag);
        issue(va, vb, vsub, vcin, tag);
        wait_result(tag);
        chk_result(tag, es, ec, eo);
        handshake(tag);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        full_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_carry1");
        full_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "add_ripple");
        full_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        full_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        full_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");

        // Backpressure with a second request held through DONE.
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "bp");
        wait_result("bp");
        req_valid = 1'b1;
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b1; cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_result($sformatf("bp_hold%0d", i), 32'h2345_6789, 1'b0, 1'b0);
            chk($sformatf("bp_hold%0d.busy", i), 64'(busy), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp.valid_dropped", 64'(rsp_valid), 64'd0);
        chk("bp.ready_back",    64'(req_ready), 64'd1);
        chk("bp.not_yet_accepted", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2.accepted", 64'(busy), 64'd1);
        wait_result("bp2");
        chk_result("bp2", 32'h5555_5555, 1'b1, 1'b1);
        handshake("bp2");

        // Abort mid-operation, then a clean operation afterwards.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        chk("abort.no_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        full_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, 32'h1122_3344, 1'b0, 1'b0, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cla_seq_add.md
Name: cla_seq_add

Overview:
- Multi-precision add/subtract sequencer. Owns one BITS-wide `cla` instance and pushes a WORDS×BITS-bit operation through it one chunk per cycle, LSB chunk first.
- Holds the inter-chunk carry in a register.
- Presents a valid/ready handshake on both the operand side and the result side.
- Sits between the register file/operand mux and the result writeback. Wide arithmetic runs without a WORDS×BITS-wide adder.

Parameters:
BITS, 8, chunk width; also the width of the instantiated `cla`.
WORDS, 4, number of chunks; total operand width W = WORDS*BITS; WORDS >= 1.

Ports:
_clk_in  input  1  clock; all state updates on the rising edge.
_rst_n_in  input  1  asynchronous, active-low reset.
_valid_in  input  1  operand request valid.
_ready_out  output  1  sequencer can accept an operand request.
_a_in  input  W  operand A.
_b_in  input  W  operand B.
_sub_in  input  1  0 = A+B+_c_in, 1 = A-B (B inverted, chunk-0 carry forced to 1, _c_in ignored).
_c_in  input  1  carry-in for the add operation.
_valid_out  output  1  result valid.
_ready_in  input  1  downstream accepts the result.
_s_out  output  W  result.
_c_out  output  1  carry out of the MSB chunk (for subtract: 1 = no borrow).
_ovf_out  output  1  two's-complement signed overflow of the W-bit result.
_busy_out  output  1  high in the RUN state.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): state = IDLE; chunk counter = 0; carry register = 0.
- Values of every output while in reset: _ready_out=1, _valid_out=0, _busy_out=0, _s_out=0, _c_out=0, _ovf_out=0.
- Reset asserted mid-operation aborts the operation immediately; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - _ready_out=1.
  - On _valid_in & _ready_out: latch A, B and _sub_in; set carry register = _sub_in ? 1 : _c_in; set counter = 0; clear _s_out; go to RUN.
- RUN:
  - _ready_out=0, _busy_out=1.
  - Each cycle, the `cla` sees chunk[counter] of A, chunk[counter] of (sub ? ~B : B), and the carry register.
  - At the clock edge: the sum is written into _s_out[counter*BITS +: BITS]; carry register <= cla carry out; counter increments.
  - When counter == WORDS-1 at the edge: go to DONE. Set _c_out = final carry and _ovf_out = (A[W-1] == Beff[W-1]) & (S[W-1] != A[W-1]), where Beff = sub ? ~B : B.
- DONE:
  - _valid_out=1, _ready_out=0.
  - _s_out, _c_out and _ovf_out stay stable until _ready_in.
  - On _valid_out & _ready_in: go to IDLE, _valid_out=0.
- Latency: the request is accepted at edge N; _valid_out rises after edge N+WORDS. Throughput is one operation per WORDS+2 cycles minimum (accept cycle, WORDS RUN cycles, one DONE handshake cycle).
- No new request is accepted in DONE, even when _ready_in is high that cycle. _ready_out rises the cycle after the result handshake.
- WORDS=1: RUN lasts exactly one cycle; the counter has width max(1, $clog2(WORDS)).
- Operands are captured at accept. Changes on _a_in/_b_in/_sub_in/_c_in after the accept edge do not affect the result.
- Arithmetic is modulo 2^W. Chunk carries propagate only through the carry register, never combinationally across chunks.
- _valid_in while _ready_out=0 is ignored. The requester must hold the request until it is accepted.

Test Plan:
- BITS=8, WORDS=4; reset; A=0x000000FF, B=0x00000001, add, c_in=0.
  - Expect _valid_out 4 cycles after accept.
  - _s_out=0x00000100, _c_out=0, _ovf_out=0.
- A=0xFFFFFFFF, B=0x00000000, add, c_in=1.
  - Ripple through all 4 chunks: _s_out=0x00000000, _c_out=1, _ovf_out=0.
- A=0x7FFFFFFF, B=0x00000001, add → _s_out=0x80000000, _c_out=0, _ovf_out=1.
- Subtract cases, with _c_in=1 driven to prove it is ignored:
  - A=0x00000005, B=0x00000007 → _s_out=0xFFFFFFFE, _c_out=0 (borrow), _ovf_out=0.
  - A=0x80000000, B=0x00000001 → _s_out=0x7FFFFFFF, _ovf_out=1.
- Backpressure: hold _ready_in=0 for 5 cycles in DONE.
  - Outputs stay stable and _ready_out stays 0.
  - Raise _ready_in → _valid_out drops next cycle; _ready_out=1 the cycle after the handshake.
  - A _valid_in held during DONE is accepted only then.
- Abort: assert _rst_n_in=0 after 2 RUN cycles.
  - All outputs at reset values immediately (asynchronous).
  - After release, a new request A=0x01020304 + B=0x10203040 → 0x11223344 with no residue from the aborted operation.
